// File: rtl/hough_pixel_stage.sv
// hough_pixel_stage
//   Pixel-stream pipeline stage for the Hough front end. Every accepted pixel
//   is stamped with its (col,row) position, taken from the frame/line
//   markers. Line and frame lengths are checked against Width/Height, and the
//   pixel can optionally be binarised. All of this is then delayed by DELAY
//   cycles.
//
//   Ports
//     Clk       in   rising-edge clock
//     Reset     in   asynchronous, active-high reset
//     PixelIn   in   input pixel
//     ValidIn   in   PixelIn/FrameIn/LineIn valid this cycle
//     FrameIn   in   first pixel of a frame (also a line start)
//     LineIn    in   first pixel of a line
//     Width     in   expected pixels per line, 0 disables the check
//     Height    in   expected lines per frame, 0 disables the check
//     Threshold in   binarise threshold (THRESH_EN=1 only)
//     PixelOut  out  delayed, optionally binarised pixel
//     ValidOut  out  delayed accepted-valid
//     FrameOut  out  delayed FrameIn
//     LineOut   out  delayed line start (LineIn or FrameIn)
//     ColOut    out  column of the output pixel
//     RowOut    out  row of the output pixel
//     LineErr   out  line-length error on the flagged pixel
//     FrameErr  out  frame-length error on the flagged pixel
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for the first FrameIn; pixels without it are dropped
//   ST_ACTIVE | inside the pixel stream; every valid pixel is accepted
module hough_pixel_stage #(
    parameter int PIXEL_W   = 8,
    parameter int DIM_W     = 8,
    parameter int DELAY     = 1,
    parameter int THRESH_EN = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [PIXEL_W-1:0] PixelIn,
    input  logic               ValidIn,
    input  logic               FrameIn,
    input  logic               LineIn,
    input  logic [DIM_W-1:0]   Width,
    input  logic [DIM_W-1:0]   Height,
    input  logic [PIXEL_W-1:0] Threshold,
    output logic [PIXEL_W-1:0] PixelOut,
    output logic               ValidOut,
    output logic               FrameOut,
    output logic               LineOut,
    output logic [DIM_W-1:0]   ColOut,
    output logic [DIM_W-1:0]   RowOut,
    output logic               LineErr,
    output logic               FrameErr
);

    // Each pipe stage carries {valid, frame, line, line_err, frame_err, col, row, pixel}.
    localparam int ST_W = PIXEL_W + 2 * DIM_W + 5;
    localparam logic [DIM_W-1:0] DIM_MAX = {DIM_W{1'b1}};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic               is_active;
    logic               accept;
    logic               line_start;
    logic [DIM_W-1:0]   col_q, row_q;
    logic [DIM_W-1:0]   col_inc, row_inc;
    logic [DIM_W-1:0]   col_nxt, row_nxt;
    logic [DIM_W-1:0]   width_m1, height_m1;
    logic               line_err, frame_err;
    logic [PIXEL_W-1:0] pix_s1;
    logic [ST_W-1:0]    stage_in;
    logic [ST_W-1:0]    pipe [DELAY];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ValidIn && FrameIn) state_nxt = ST_ACTIVE;
            ST_ACTIVE: state_nxt = ST_ACTIVE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign is_active  = (state == ST_ACTIVE);
    assign accept     = ValidIn & (is_active | FrameIn);
    assign line_start = FrameIn | LineIn;

    // ------------------------------------------------------------------
    // Coordinates of the current pixel. Both counters saturate and never wrap.
    // ------------------------------------------------------------------
    assign col_inc = (col_q == DIM_MAX) ? col_q : col_q + DIM_W'(1);
    assign row_inc = (row_q == DIM_MAX) ? row_q : row_q + DIM_W'(1);

    always_comb begin
        col_nxt = col_inc;
        row_nxt = row_q;
        if (FrameIn) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (LineIn) begin
            col_nxt = '0;
            row_nxt = row_inc;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            col_q <= col_nxt;
            row_q <= row_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Length checks. The excess check fires only on the step from Width-1 to
    // Width. This means a saturated counter cannot flag the same line twice.
    // Width/Height are non-zero whenever a check is enabled, so the minus-one
    // values never underflow in a term that is used.
    // ------------------------------------------------------------------
    assign width_m1  = Width  - DIM_W'(1);
    assign height_m1 = Height - DIM_W'(1);

    assign line_err  = (Width != '0) &&
                       ((is_active && line_start && (col_q < width_m1)) ||
                        (!line_start && (col_q == width_m1)));

    assign frame_err = (Height != '0) &&
                       ((is_active && FrameIn && (row_q < height_m1)) ||
                        (LineIn && !FrameIn && (row_q == height_m1)));

    // ------------------------------------------------------------------
    // Optional binarisation at stage 1
    // ------------------------------------------------------------------
    generate
        if (THRESH_EN != 0) begin : g_thresh
            assign pix_s1 = (PixelIn >= Threshold) ? {PIXEL_W{1'b1}} : '0;
        end else begin : g_pass
            assign pix_s1 = PixelIn;
        end
    endgenerate

    // A cycle that is not accepted becomes an all-zero bubble. This keeps the
    // outputs at zero on non-valid cycles without any extra output gating.
    assign stage_in = accept ? {1'b1, FrameIn, line_start, line_err, frame_err,
                                col_nxt, row_nxt, pix_s1}
                             : '0;

    // ------------------------------------------------------------------
    // Delay line
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {ValidOut, FrameOut, LineOut, LineErr, FrameErr,
            ColOut, RowOut, PixelOut} = pipe[DELAY-1];

endmodule
